// File: rtl/aes_sbox_sched_pkg.sv
// Shared types for the masked S-box share scheduler: requester ids and the
// in-flight tag carried alongside each gadget token.
package aes_sbox_sched_pkg;

    typedef enum logic {
        REQ_ST = 1'b0,
        REQ_KS = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } tag_t;

    localparam int SBOX_LAT_MIN = 1;
    localparam int SBOX_LAT_MAX = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the priority pointer moves only when the
// caller reports that the current grant was actually used.
module rr_arbiter2
    import aes_sbox_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_st,
    input  logic req_ks,
    input  logic advance,
    output logic grant_valid,
    output logic grant_ks
);

    req_id_e prio_r;

    // Grant selection: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        grant_valid = req_st | req_ks;
        if (req_st && req_ks) begin
            grant_ks = (prio_r == REQ_KS);
        end else if (req_ks) begin
            grant_ks = 1'b1;
        end else begin
            grant_ks = 1'b0;
        end
    end

    // Priority pointer: after a used grant, the other requester is favoured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_r <= REQ_ST;
        end else if (advance && grant_valid) begin
            prio_r <= grant_ks ? REQ_ST : REQ_KS;
        end
    end

endmodule

// File: rtl/aes_sbox_share_scheduler.sv
// Issues masked bytes from the state and key-schedule requesters into the
// shared GHPC S-box gadget and routes fixed-latency results back by tag.
module aes_sbox_share_scheduler
    import aes_sbox_sched_pkg::*;
#(
    parameter int SBOX_LAT = 2,
    parameter int PIPELINE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       st_valid,
    output logic       st_ready,
    input  logic [7:0] st_in0,
    input  logic [7:0] st_in1,
    input  logic       ks_valid,
    output logic       ks_ready,
    input  logic [7:0] ks_in0,
    input  logic [7:0] ks_in1,
    input  logic       rnd_valid,
    output logic       rnd_ready,
    input  logic [7:0] rnd,
    output logic [7:0] sb_in0,
    output logic [7:0] sb_in1,
    output logic [7:0] sb_r,
    output logic       sb_en,
    input  logic [7:0] sb_out0,
    input  logic [7:0] sb_out1,
    output logic       st_ovalid,
    output logic [7:0] st_out0,
    output logic [7:0] st_out1,
    output logic       ks_ovalid,
    output logic [7:0] ks_out0,
    output logic [7:0] ks_out1,
    output logic       busy
);

    logic grant_valid_s;
    logic grant_ks_s;
    logic issue_s;
    logic busy_s;
    logic sb_en_s;
    tag_t tag_r [SBOX_LAT];
    tag_t retire_s;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_st      (st_valid),
        .req_ks      (ks_valid),
        .advance     (issue_s),
        .grant_valid (grant_valid_s),
        .grant_ks    (grant_ks_s)
    );

    // Occupancy of the tag pipeline.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < SBOX_LAT; i++) begin
            busy_s = busy_s | tag_r[i].valid;
        end
    end

    // Issue needs fresh randomness; without pipelining the gadget must be empty.
    assign issue_s  = rst_n & rnd_valid & grant_valid_s & ((PIPELINE != 0) | ~busy_s);
    assign sb_en_s  = rst_n & (issue_s | busy_s);
    assign sb_en    = sb_en_s;
    assign busy     = rst_n & busy_s;
    assign retire_s = tag_r[SBOX_LAT-1];

    // Issue-side mux; randomness is only forwarded when it is consumed.
    always_comb begin
        st_ready  = 1'b0;
        ks_ready  = 1'b0;
        rnd_ready = 1'b0;
        sb_in0    = 8'h00;
        sb_in1    = 8'h00;
        sb_r      = 8'h00;
        if (issue_s) begin
            rnd_ready = 1'b1;
            sb_r      = rnd;
            if (grant_ks_s) begin
                ks_ready = 1'b1;
                sb_in0   = ks_in0;
                sb_in1   = ks_in1;
            end else begin
                st_ready = 1'b1;
                sb_in0   = st_in0;
                sb_in1   = st_in1;
            end
        end else begin
            rnd_ready = 1'b0;
            sb_r      = 8'h00;
        end
    end

    // Tag pipeline advances in lockstep with the gadget clock enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SBOX_LAT; i++) begin
                tag_r[i] <= '{valid: 1'b0, id: REQ_ST};
            end
        end else if (sb_en_s) begin
            tag_r[0].valid <= issue_s;
            tag_r[0].id    <= grant_ks_s ? REQ_KS : REQ_ST;
            for (int i = 1; i < SBOX_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Result routing: only the owning requester sees the gadget shares.
    always_comb begin
        st_ovalid = 1'b0;
        ks_ovalid = 1'b0;
        st_out0   = 8'h00;
        st_out1   = 8'h00;
        ks_out0   = 8'h00;
        ks_out1   = 8'h00;
        if (rst_n && retire_s.valid) begin
            if (retire_s.id == REQ_KS) begin
                ks_ovalid = 1'b1;
                ks_out0   = sb_out0;
                ks_out1   = sb_out1;
            end else begin
                st_ovalid = 1'b1;
                st_out0   = sb_out0;
                st_out1   = sb_out1;
            end
        end else begin
            st_ovalid = 1'b0;
            ks_ovalid = 1'b0;
        end
    end

endmodule
